// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if: bus between the ALU result source and the seven-segment scan driver.
//   Value [8:0] : result to display, {Cout,Sum}
//   Mode        : 0 = decimal, 1 = hex
//   SSD   [7:0] : active-low segments, SSD[7] = dp, SSD[6:0] = g..a
//   An    [3:0] : active-low one-hot digit enables, An[0] = rightmost digit
//   Valid       : one-cycle pulse when a new conversion is committed
interface ssd_scan_driver_if;
    logic [8:0] Value;
    logic       Mode;
    logic [7:0] SSD;
    logic [3:0] An;
    logic       Valid;
    modport master (output Value, Mode, input SSD, An, Valid);
    modport slave  (input Value, Mode, output SSD, An, Valid);
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: converts the 9-bit ALU result to decimal/hex digits and scans a 4-digit display.
//   Clk   : system clock, rising edge
//   Rst_n : synchronous active-low reset
//   bus   : slave side of ssd_scan_driver_if (Value/Mode in, SSD/An/Valid out)
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    ssd_scan_driver_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] LET_D = 7'h21;
    localparam logic [6:0] LET_H = 7'h09;

    typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} state_t;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    state_t          state;
    logic [8:0]      shadow;
    logic            mode_s;
    logic [8:0]      bin;
    logic [11:0]     bcd;
    logic [3:0]      bitcnt;
    logic [3:0][6:0] dig;
    logic [PW-1:0]   pre;
    logic [1:0]      idx;

    logic [11:0]     bcd_adj;
    logic [3:0]      n0, n1, n2;
    logic            b1, b2;
    logic            commit;
    logic            wrap;
    logic [1:0]      idx_n;
    logic [3:0][6:0] dn;

    // Double-dabble correction: bump any BCD nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + ((bcd[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end

    assign n0     = mode_s ? shadow[3:0] : bcd[3:0];
    assign n1     = mode_s ? shadow[7:4] : bcd[7:4];
    assign n2     = mode_s ? {3'b000, shadow[8]} : bcd[11:8];
    assign b2     = BLANK_LZ && (n2 == 4'd0);
    assign b1     = b2 && (n1 == 4'd0);
    assign commit = (state == COMMIT);
    assign wrap   = (pre == PW'(REFRESH_DIV - 1));
    assign idx_n  = wrap ? idx + 2'd1 : idx;

    // Next digit contents, so a commit landing on a scan advance is shown immediately.
    always_comb begin
        dn = dig;
        if (commit) begin
            dn[0] = seg(n0);
            dn[1] = b1 ? BLANK : seg(n1);
            dn[2] = b2 ? BLANK : seg(n2);
            dn[3] = mode_s ? LET_H : LET_D;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= LOAD;
            shadow    <= '0;
            mode_s    <= 1'b0;
            bin       <= '0;
            bcd       <= '0;
            bitcnt    <= '0;
            dig       <= {4{BLANK}};
            pre       <= '0;
            idx       <= '0;
            bus.SSD   <= 8'hFF;
            bus.An    <= 4'hF;
            bus.Valid <= 1'b0;
        end else begin
            bus.Valid <= commit;
            dig       <= dn;
            pre       <= wrap ? '0 : pre + 1'b1;
            idx       <= idx_n;
            bus.An    <= ~(4'b0001 << idx_n);
            bus.SSD   <= {1'b1, dn[idx_n]};
            case (state)
                LOAD: begin
                    shadow <= bus.Value;
                    mode_s <= bus.Mode;
                    bin    <= bus.Value;
                    bcd    <= '0;
                    bitcnt <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
                    bitcnt     <= bitcnt + 4'd1;
                    state      <= (bitcnt == 4'd8) ? COMMIT : SHIFT;
                end
                COMMIT:  state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench driving two drivers (BLANK_LZ=0 and 1) with directed vectors.
module tb_ssd_scan_driver;
    typedef logic [1:0][3:0][7:0] exp_t;   // [dut][digit] expected SSD byte

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    logic rst_q = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   since = 0;
    exp_t sb[$];
    exp_t cur = '1;

    always #5 Clk = ~Clk;

    ssd_scan_driver_if b0();
    ssd_scan_driver_if b1();

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u0 (.Clk(Clk), .Rst_n(Rst_n), .bus(b0));
    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u1 (.Clk(Clk), .Rst_n(Rst_n), .bus(b1));

    logic [7:0] ssd [2];
    logic [3:0] an  [2];
    logic       vld [2];
    assign ssd[0] = b0.SSD;
    assign ssd[1] = b1.SSD;
    assign an[0]  = b0.An;
    assign an[1]  = b1.An;
    assign vld[0] = b0.Valid;
    assign vld[1] = b1.Valid;

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, act, exp);
        end
    endtask

    always @(posedge Clk) rst_q <= Rst_n;

    // Monitor: reset state, Valid cadence, scan order and displayed segments per cycle.
    always @(negedge Clk) begin
        if (!rst_q) begin
            since = 0;
            cur = '1;
            for (int k = 0; k < 2; k++) begin
                chk("reset_ssd", k, ssd[k], 8'hFF);
                chk("reset_an", k, {4'h0, an[k]}, 8'h0F);
                chk("reset_valid", k, {7'h0, vld[k]}, 8'h00);
            end
        end else begin
            int         di;
            logic [3:0] ean;
            logic       ev;
            since++;
            di  = (since / 4) % 4;
            ean = ~(4'b0001 << di);
            ev  = (since % 11 == 0);
            if (vld[0] || vld[1]) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid t=%0t got pulse want none queued", $time);
                end else cur = sb.pop_front();
            end
            for (int k = 0; k < 2; k++) begin
                chk("valid", k, {7'h0, vld[k]}, {7'h0, ev});
                chk("an", k, {4'h0, an[k]}, {4'h0, ean});
                chk("ssd", k, ssd[k], cur[k][di]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic set(input logic [8:0] v, input logic m);
        b0.Value = v;
        b1.Value = v;
        b0.Mode  = m;
        b1.Mode  = m;
    endtask

    task automatic frame(input logic [8:0] v, input logic m, input exp_t e);
        set(v, m);
        sb.push_back(e);
        tick(11);
    endtask

    logic [8:0] tv [8];
    logic       tm [8];
    exp_t       te [8];
    exp_t       e511, ezero, ehex;

    initial begin
        // {dut1 (BLANK_LZ=1) digits 3..0, dut0 (BLANK_LZ=0) digits 3..0}
        tv[0] = 9'd300;  tm[0] = 1'b0; te[0] = {32'hA1B0C0C0, 32'hA1B0C0C0};
        tv[1] = 9'd7;    tm[1] = 1'b0; te[1] = {32'hA1FFFFF8, 32'hA1C0C0F8};
        tv[2] = 9'h1AB;  tm[2] = 1'b1; te[2] = {32'h89F98883, 32'h89F98883};
        tv[3] = 9'd109;  tm[3] = 1'b0; te[3] = {32'hA1F9C090, 32'hA1F9C090};
        tv[4] = 9'd45;   tm[4] = 1'b0; te[4] = {32'hA1FF9992, 32'hA1C09992};
        tv[5] = 9'd256;  tm[5] = 1'b0; te[5] = {32'hA1A49282, 32'hA1A49282};
        tv[6] = 9'h00F;  tm[6] = 1'b1; te[6] = {32'h89FFFF8E, 32'h89C0C08E};
        tv[7] = 9'h050;  tm[7] = 1'b1; te[7] = {32'h89FF92C0, 32'h89C092C0};
        e511  = {32'hA192F9F9, 32'hA192F9F9};
        ezero = {32'hA1FFFFC0, 32'hA1C0C0C0};
        ehex  = {32'h89F98E8E, 32'h89F98E8E};

        set(9'd0, 1'b0);
        tick(3);
        Rst_n = 1'b1;
        // Each vector is held for two results so every digit slot is scanned.
        for (int i = 0; i < 8; i++) begin
            frame(tv[i], tm[i], te[i]);
            frame(tv[i], tm[i], te[i]);
        end
        // Value changes after LOAD: first commit keeps 511, next one picks up 0.
        set(9'd511, 1'b0);
        sb.push_back(e511);
        tick(3);
        set(9'd0, 1'b0);
        sb.push_back(ezero);
        tick(8);
        tick(11);
        frame(9'd0, 1'b0, ezero);
        // Reset in the middle of SHIFT: nothing from that conversion may commit.
        set(9'd123, 1'b0);
        tick(4);
        Rst_n = 1'b0;
        tick(1);
        Rst_n = 1'b1;
        frame(9'h1FF, 1'b1, ehex);
        frame(9'h1FF, 1'b1, ehex);
        @(negedge Clk);
        #1;
        chk("scoreboard_drained", 0, 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
